cache_system_param: RTL and testbench

Parametrised successor to the fixed 8-line cache + controller + memory interface stack. It is a single block containing a write-back, write-allocate cache that can be direct-mapped or 2-way set-associative, plus its miss/flush controller. Line size and set count are configurable. The block sits between the CPU load/store path (16-bit word address and data) and an external line-wide memory port using an enable/done handshake. New relative to the previous generation: associativity with LRU replacement, parametrised line width, and a full dirty-line flush reported line by line.

---
 rtl/cache_system_param.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_cache_system_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_system_param.sv
// Write-back, write-allocate cache (direct-mapped or 2-way LRU) with its miss/flush
// controller, between a 16-bit CPU load/store path and a line-wide memory port.
module cache_system_param #(
    parameter int WORDS_PER_LINE = 4,
    parameter int INDEX_BITS     = 3,
    parameter int WAYS           = 2,
    localparam int OFF           = $clog2(WORDS_PER_LINE),
    localparam int LW            = 16 * WORDS_PER_LINE,
    localparam int LA            = 16 - OFF,
    localparam int TAG           = 16 - OFF - INDEX_BITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          rd_wrt_ca,
    input  logic [15:0]   addr_ca,
    input  logic [15:0]   data_ca_in,
    input  logic          flush,
    output logic [15:0]   data_ca_out,
    output logic          done,
    output logic          idle,
    output logic          one_line_flushed,
    output logic          flush_finish,
    output logic [LA-1:0] addr_mem,
    output logic [LW-1:0] data_to_mem,
    input  logic [LW-1:0] data_from_mem,
    output logic          rd_wrt_mem,
    output logic          mem_enable,
    input  logic          done_mem
);

    localparam int SETS   = 1 << INDEX_BITS;
    localparam int SCAN_W = INDEX_BITS + 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SETS * WAYS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB, S_FILL, S_COMPLETE, S_FL_SCAN, S_FL_WB, S_FL_END
    } state_t;

    state_t              state_reg, state_next;
    logic [15:0]         req_addr_reg;
    logic [15:0]         req_data_reg;
    logic                req_rd_reg;
    logic                victim_reg;
    logic [SCAN_W-1:0]   scan_ptr_reg, scan_ptr_next;
    logic [SETS-1:0]     valid_reg [2];
    logic [SETS-1:0]     dirty_reg [2];
    logic [SETS-1:0]     lru_reg;
    logic [LW-1:0]       fill_line_reg;
    logic [15:0]         data_out_reg;

    logic [OFF-1:0]        req_off;
    logic [INDEX_BITS-1:0] req_idx, cpu_idx, scan_idx, rd_index;
    logic [TAG-1:0]        req_tag;
    logic [LA-1:0]         req_line;
    logic                  scan_wy, scan_dirty;
    logic [LW-1:0]         rd_line [2];
    logic [TAG-1:0]        rd_tag [2];
    logic [1:0]            hit_vec;
    logic                  hit, hit_way, victim_comb, victim_dirty;
    logic [LW-1:0]         hit_line;
    logic                  data_we, tag_we, wr_way;
    logic [LW-1:0]         wr_data;

    function automatic logic [15:0] get_word(input logic [LW-1:0] line, input logic [OFF-1:0] off);
        get_word = line[{off, 4'b0000} +: 16];
    endfunction

    function automatic logic [LW-1:0] put_word(input logic [LW-1:0] line, input logic [OFF-1:0] off,
                                               input logic [15:0] w);
        put_word = line;
        put_word[{off, 4'b0000} +: 16] = w;
    endfunction

    // Scan pointer enumerates entries as index-major, way-minor.
    function automatic logic [INDEX_BITS-1:0] scan_index(input logic [SCAN_W-1:0] p);
        if (WAYS == 2) scan_index = p[INDEX_BITS:1];
        else           scan_index = p[INDEX_BITS-1:0];
    endfunction

    function automatic logic scan_way(input logic [SCAN_W-1:0] p);
        scan_way = (WAYS == 2) ? p[0] : 1'b0;
    endfunction

    assign req_off  = req_addr_reg[OFF-1:0];
    assign req_idx  = req_addr_reg[OFF+INDEX_BITS-1:OFF];
    assign req_tag  = req_addr_reg[15:OFF+INDEX_BITS];
    assign req_line = req_addr_reg[15:OFF];
    assign cpu_idx  = addr_ca[OFF+INDEX_BITS-1:OFF];
    assign scan_idx = scan_index(scan_ptr_reg);
    assign scan_wy  = scan_way(scan_ptr_reg);
    assign scan_dirty = valid_reg[scan_wy][scan_idx] & dirty_reg[scan_wy][scan_idx];

    // Per-way line/tag RAMs, read-first with a registered read port.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            if (gi < WAYS) begin : g_ram
                logic [LW-1:0]  data_ram [SETS];
                logic [TAG-1:0] tag_ram  [SETS];
                logic [LW-1:0]  line_q;
                logic [TAG-1:0] tag_q;
                always_ff @(posedge clk) begin
                    if (data_we && wr_way == 1'(gi)) data_ram[req_idx] <= wr_data;
                    if (tag_we && wr_way == 1'(gi))  tag_ram[req_idx]  <= req_tag;
                    line_q <= data_ram[rd_index];
                    tag_q  <= tag_ram[rd_index];
                end
                assign rd_line[gi] = line_q;
                assign rd_tag[gi]  = tag_q;
            end else begin : g_none
                assign rd_line[gi] = '0;
                assign rd_tag[gi]  = '0;
            end
        end
    endgenerate

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < 2; w++)
            hit_vec[w] = valid_reg[w][req_idx] && (rd_tag[w] == req_tag);
    end
    assign hit      = |hit_vec;
    assign hit_way  = hit_vec[1];
    assign hit_line = rd_line[hit_way];

    // Prefer an empty way; otherwise evict the least recently used one.
    always_comb begin
        if (WAYS == 1 || !valid_reg[0][req_idx]) victim_comb = 1'b0;
        else if (!valid_reg[1][req_idx])         victim_comb = 1'b1;
        else                                     victim_comb = lru_reg[req_idx];
    end
    assign victim_dirty = valid_reg[victim_comb][req_idx] & dirty_reg[victim_comb][req_idx];

    always_comb begin
        state_next    = state_reg;
        scan_ptr_next = scan_ptr_reg;
        case (state_reg)
            S_IDLE: begin
                if (flush) begin
                    state_next    = S_FL_SCAN;
                    scan_ptr_next = '0;
                end else if (enable) begin
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP:   state_next = hit ? S_IDLE : (victim_dirty ? S_WB : S_FILL);
            S_WB:       if (done_mem) state_next = S_FILL;
            S_FILL:     if (done_mem) state_next = S_COMPLETE;
            S_COMPLETE: state_next = S_IDLE;
            S_FL_SCAN: begin
                if (scan_dirty) begin
                    state_next = S_FL_WB;
                end else if (scan_ptr_reg == SCAN_LAST) begin
                    state_next = S_FL_END;
                end else begin
                    scan_ptr_next = scan_ptr_reg + 1'b1;
                end
            end
            S_FL_WB: begin
                if (done_mem) begin
                    scan_ptr_next = scan_ptr_reg + 1'b1;
                    state_next    = (scan_ptr_reg == SCAN_LAST) ? S_FL_END : S_FL_SCAN;
                end
            end
            S_FL_END:   state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Read address targets whatever line the next state will look at.
    always_comb begin
        if (state_next == S_FL_SCAN || state_next == S_FL_WB) rd_index = scan_index(scan_ptr_next);
        else if (state_reg == S_IDLE)                         rd_index = cpu_idx;
        else                                                  rd_index = req_idx;
    end

    always_comb begin
        data_we = 1'b0;
        tag_we  = 1'b0;
        wr_way  = 1'b0;
        wr_data = '0;
        case (state_reg)
            S_LOOKUP: begin
                if (hit && !req_rd_reg) begin
                    data_we = 1'b1;
                    wr_way  = hit_way;
                    wr_data = put_word(hit_line, req_off, req_data_reg);
                end
            end
            S_FILL: begin
                tag_we = done_mem;
                wr_way = victim_reg;
            end
            S_COMPLETE: begin
                data_we = 1'b1;
                wr_way  = victim_reg;
                wr_data = req_rd_reg ? fill_line_reg : put_word(fill_line_reg, req_off, req_data_reg);
            end
            default: ;
        endcase
    end

    always_comb begin
        idle             = 1'b0;
        done             = 1'b0;
        mem_enable       = 1'b0;
        rd_wrt_mem       = 1'b0;
        addr_mem         = '0;
        data_to_mem      = '0;
        one_line_flushed = 1'b0;
        flush_finish     = 1'b0;
        case (state_reg)
            S_IDLE:     idle = 1'b1;
            S_LOOKUP:   done = hit;
            S_WB: begin
                mem_enable  = 1'b1;
                addr_mem    = {rd_tag[victim_reg], req_idx};
                data_to_mem = rd_line[victim_reg];
            end
            S_FILL: begin
                mem_enable = 1'b1;
                rd_wrt_mem = 1'b1;
                addr_mem   = req_line;
            end
            S_COMPLETE: done = 1'b1;
            S_FL_WB: begin
                mem_enable       = 1'b1;
                addr_mem         = {rd_tag[scan_wy], scan_idx};
                data_to_mem      = rd_line[scan_wy];
                one_line_flushed = done_mem;
            end
            S_FL_END:   flush_finish = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            req_addr_reg  <= '0;
            req_data_reg  <= '0;
            req_rd_reg    <= 1'b0;
            victim_reg    <= 1'b0;
            scan_ptr_reg  <= '0;
            lru_reg       <= '0;
            fill_line_reg <= '0;
            data_out_reg  <= '0;
            for (int w = 0; w < 2; w++) begin
                valid_reg[w] <= '0;
                dirty_reg[w] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            scan_ptr_reg <= scan_ptr_next;
            case (state_reg)
                S_IDLE: begin
                    if (enable && !flush) begin
                        req_addr_reg <= addr_ca;
                        req_data_reg <= data_ca_in;
                        req_rd_reg   <= rd_wrt_ca;
                    end
                end
                S_LOOKUP: begin
                    victim_reg <= victim_comb;
                    if (hit) begin
                        if (WAYS == 2) lru_reg[req_idx] <= ~hit_way;
                        if (req_rd_reg) data_out_reg <= get_word(hit_line, req_off);
                        else            dirty_reg[hit_way][req_idx] <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (done_mem) begin
                        valid_reg[victim_reg][req_idx] <= 1'b1;
                        dirty_reg[victim_reg][req_idx] <= 1'b0;
                        fill_line_reg <= data_from_mem;
                    end
                end
                S_COMPLETE: begin
                    if (WAYS == 2) lru_reg[req_idx] <= ~victim_reg;
                    if (req_rd_reg) data_out_reg <= get_word(fill_line_reg, req_off);
                    else            dirty_reg[victim_reg][req_idx] <= 1'b1;
                end
                S_FL_WB: begin
                    if (done_mem) dirty_reg[scan_wy][scan_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign data_ca_out = data_out_reg;

endmodule

// File: tb/tb_cache_system_param.sv
// Directed bench for cache_system_param: scoreboard queues for CPU completions and
// memory requests, checked by monitors independent of the stimulus.
module tb_cache_system_param;

    logic        clk, rst, enable, rd_wrt_ca, flush;
    logic [15:0] addr_ca, data_ca_in, data_ca_out;
    logic        done, idle, one_line_flushed, flush_finish;
    logic [13:0] addr_mem;
    logic [63:0] data_to_mem, data_from_mem;
    logic        rd_wrt_mem, mem_enable, done_mem;

    cache_system_param dut (
        .clk(clk), .rst(rst), .enable(enable), .rd_wrt_ca(rd_wrt_ca), .addr_ca(addr_ca),
        .data_ca_in(data_ca_in), .flush(flush), .data_ca_out(data_ca_out), .done(done),
        .idle(idle), .one_line_flushed(one_line_flushed), .flush_finish(flush_finish),
        .addr_mem(addr_mem), .data_to_mem(data_to_mem), .data_from_mem(data_from_mem),
        .rd_wrt_mem(rd_wrt_mem), .mem_enable(mem_enable), .done_mem(done_mem)
    );

    typedef struct {
        logic [15:0] data;
        string       name;
    } cpu_exp_t;

    typedef struct {
        logic        rd;
        logic [13:0] addr;
        logic        chk_word;
        int          widx;
        logic [15:0] word;
        string       name;
    } mem_exp_t;

    cpu_exp_t    done_q[$];
    mem_exp_t    mem_q[$];
    logic [63:0] store [logic [13:0]];
    int checks = 0, errors = 0;
    int mem_req_count = 0, done_count = 0, lines_flushed = 0, finishes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_line(input logic [13:0] la);
        logic [63:0] l;
        if (store.exists(la)) return store[la];
        if (la == 14'h0004) return 64'h0004_0003_0002_0001;
        for (int i = 0; i < 4; i++) l[16*i +: 16] = {la[11:0], 4'(i)};
        return l;
    endfunction

    task automatic push_mem(input logic rd, input logic [13:0] a, input logic cw, input int wi,
                            input logic [15:0] w, input string name);
        mem_exp_t m;
        m.rd = rd; m.addr = a; m.chk_word = cw; m.widx = wi; m.word = w; m.name = name;
        mem_q.push_back(m);
    endtask

    // Memory model: done_mem three cycles after a request is seen; checks each new request.
    initial begin
        int cnt = 0;
        mem_exp_t m;
        done_mem = 1'b0;
        data_from_mem = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                done_mem = 1'b0; cnt = 0;
            end else if (done_mem) begin
                done_mem = 1'b0; cnt = 0;
            end else if (mem_enable) begin
                if (cnt == 0) begin
                    mem_req_count++;
                    if (mem_q.size() == 0) begin
                        chk("unexpected mem request", mem_enable, 0);
                    end else begin
                        m = mem_q.pop_front();
                        $display("mem req %s: rd=%0b addr=%h", m.name, rd_wrt_mem, addr_mem);
                        chk({m.name, " rd_wrt_mem"}, rd_wrt_mem, m.rd);
                        chk({m.name, " addr_mem"}, addr_mem, m.addr);
                        if (m.chk_word) chk({m.name, " wb word"}, data_to_mem[16*m.widx +: 16], m.word);
                    end
                end
                cnt++;
                if (cnt == 3) begin
                    if (rd_wrt_mem) data_from_mem = mem_line(addr_mem);
                    else            store[addr_mem] = data_to_mem;
                    done_mem = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Completion monitor: each done pops one expectation; data_ca_out is registered.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                if (done_q.size() == 0) begin
                    chk("unexpected done", done, 0);
                end else begin
                    e = done_q.pop_front();
                    @(posedge clk); #1;
                    $display("done %s: data_ca_out=%h", e.name, data_ca_out);
                    chk({e.name, " data_ca_out"}, data_ca_out, e.data);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (one_line_flushed === 1'b1) lines_flushed++;
            if (flush_finish === 1'b1) finishes++;
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && idle !== 1'b1; i++) @(negedge clk);
        chk({name, " idle reached"}, idle, 1);
    endtask

    task automatic cpu_access(input logic rd, input logic [15:0] a, input logic [15:0] wd,
                              input logic [15:0] exp_d, input logic exp_hit, input string name);
        cpu_exp_t e;
        int base;
        base = mem_req_count;
        e.data = exp_d; e.name = name;
        done_q.push_back(e);
        enable = 1'b1; rd_wrt_ca = rd; addr_ca = a; data_ca_in = wd;
        @(negedge clk);
        enable = 1'b0;
        chk({name, " done at T+1"}, done, exp_hit);
        wait_idle(name);
        if (exp_hit) chk({name, " mem traffic"}, mem_req_count, base);
    endtask

    task automatic do_flush(input logic with_en, input int exp_wb, input int exp_cyc, input string name);
        int cyc, l0, f0, m0, d0;
        l0 = lines_flushed; f0 = finishes; m0 = mem_req_count; d0 = done_count;
        flush = 1'b1;
        if (with_en) begin
            enable = 1'b1; rd_wrt_ca = 1'b1; addr_ca = 16'h0010;
        end
        @(negedge clk);
        flush = 1'b0; enable = 1'b0; cyc = 1;
        while (flush_finish !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, " flush_finish seen"}, flush_finish, 1);
        if (exp_cyc > 0) chk({name, " cycles"}, cyc, exp_cyc);
        @(negedge clk); #1;
        $display("flush %s: cycles=%0d lines=%0d finishes=%0d", name, cyc, lines_flushed - l0, finishes - f0);
        chk({name, " one_line_flushed"}, lines_flushed - l0, exp_wb);
        chk({name, " flush_finish count"}, finishes - f0, 1);
        chk({name, " write-backs"}, mem_req_count - m0, exp_wb);
        chk({name, " no done"}, done_count - d0, 0);
        chk({name, " idle"}, idle, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; rd_wrt_ca = 1'b0; flush = 1'b0;
        addr_ca = '0; data_ca_in = '0;
        repeat (2) @(negedge clk);
        chk("reset idle", idle, 1);
        chk("reset done", done, 0);
        chk("reset mem_enable", mem_enable, 0);
        chk("reset data_ca_out", data_ca_out, 0);
        chk("reset flush_finish", flush_finish, 0);
        rst = 1'b0;
        @(negedge clk);

        push_mem(1'b1, 14'h0004, 1'b0, 0, 16'h0, "cold_rd fill");
        cpu_access(1'b1, 16'h0010, 16'h0, 16'h0001, 1'b0, "cold_rd");
        cpu_access(1'b1, 16'h0011, 16'h0, 16'h0002, 1'b1, "hit_rd");
        cpu_access(1'b0, 16'h0012, 16'hBEEF, 16'h0002, 1'b1, "hit_wr");
        cpu_access(1'b1, 16'h0012, 16'h0, 16'hBEEF, 1'b1, "hit_rd_beef");

        cpu_access(1'b0, 16'h0012, 16'hBEEF, 16'hBEEF, 1'b1, "lru_wr");
        push_mem(1'b1, 14'h000C, 1'b0, 0, 16'h0, "fill_w1 fill");
        cpu_access(1'b1, 16'h0030, 16'h0, 16'h00C0, 1'b0, "fill_w1");
        push_mem(1'b0, 14'h0004, 1'b1, 2, 16'hBEEF, "evict wb");
        push_mem(1'b1, 14'h0014, 1'b0, 0, 16'h0, "evict fill");
        cpu_access(1'b1, 16'h0050, 16'h0, 16'h0140, 1'b0, "evict");
        cpu_access(1'b1, 16'h0030, 16'h0, 16'h00C0, 1'b1, "lru_keep");

        push_mem(1'b1, 14'h0015, 1'b0, 0, 16'h0, "wr_miss fill");
        cpu_access(1'b0, 16'h0054, 16'h1234, 16'h00C0, 1'b0, "wr_miss");
        cpu_access(1'b0, 16'h0031, 16'h5678, 16'h00C0, 1'b1, "wr_hit2");

        push_mem(1'b0, 14'h000C, 1'b1, 1, 16'h5678, "flush wb set4");
        push_mem(1'b0, 14'h0015, 1'b1, 0, 16'h1234, "flush wb set5");
        do_flush(1'b0, 2, 0, "flush_dirty");
        do_flush(1'b0, 0, 17, "flush_clean");
        do_flush(1'b1, 0, 17, "flush_vs_en");

        push_mem(1'b1, 14'h0024, 1'b0, 0, 16'h0, "rst_fill");
        enable = 1'b1; rd_wrt_ca = 1'b1; addr_ca = 16'h0090;
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 20 && mem_enable !== 1'b1; i++) @(negedge clk);
        chk("rst_fill mem_enable before reset", mem_enable, 1);
        rst = 1'b1;
        #1;
        $display("reset in FILL: mem_enable=%0b idle=%0b", mem_enable, idle);
        chk("rst mem_enable drop", mem_enable, 0);
        chk("rst idle", idle, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_mem(1'b1, 14'h0004, 1'b0, 0, 16'h0, "post_rst fill");
        cpu_access(1'b1, 16'h0010, 16'h0, 16'h0001, 1'b0, "post_rst");

        repeat (3) @(negedge clk);
        chk("mem queue drained", mem_q.size(), 0);
        chk("done queue drained", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
